// File: rtl/scratch_pad_seq_reader_pkg.sv
// scratch_pad_seq_reader_pkg: shared FSM encoding and request-budget defaults
package scratch_pad_seq_reader_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
  localparam int REORDER_DEPTH = 32;
  localparam int MAX_OUTSTANDING_DEF = REORDER_DEPTH;
endpackage

// File: rtl/scratch_pad_seq_reader_skid_buffer.sv
// sp_skid_buffer: 2-entry valid/ready FIFO with a registered stall output
module sp_skid_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_stall,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_q, rd_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;
  assign in_stall  = cnt_q[1];
  assign out_valid = cnt_q != 2'd0;
  assign out_data  = mem_q[rd_q];
  // write at the slot behind the head, advance the head on pop
  always_comb begin
    push  = in_valid && !cnt_q[1];
    pop   = out_valid && out_ready;
    mem_d = mem_q;
    if (push) mem_d[rd_q ^ cnt_q[0]] = in_data;
    rd_d  = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end
  // buffer state registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem_q <= '{default: '0};
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/scratch_pad_seq_reader.sv
// scratch_pad_seq_reader: strided read sequencer for one scratch_pad port
module scratch_pad_seq_reader
  import scratch_pad_seq_reader_pkg::*;
#(
  parameter int WIDTH           = 64,
  parameter int ADDR_WIDTH      = 12,
  parameter int LEN_WIDTH       = 13,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int OUT_BITS        = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [ADDR_WIDTH-1:0] stride,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  sp_rd_en,
  output logic [ADDR_WIDTH-1:0] sp_addr,
  input  logic                  sp_full,
  input  logic [WIDTH-1:0]      sp_q,
  input  logic                  sp_valid,
  output logic                  sp_stall,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, stride_q, stride_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [OUT_BITS-1:0]   out_q, out_d;
  logic                  err_q, err_d;
  logic                  xfer, dec;
  assign sp_addr = addr_q;
  assign busy    = state_q != IDLE;
  assign done    = state_q == FIN;
  assign err     = err_q;
  assign xfer    = sp_valid && !sp_stall;
  // issue gating, outstanding budget, address generation and next state
  always_comb begin
    sp_rd_en = state_q == ISSUE && !sp_full && out_q < OUT_BITS'(MAX_OUTSTANDING) && rem_q != '0;
    dec      = xfer && (out_q != '0 || sp_rd_en);
    out_d    = out_q + OUT_BITS'(sp_rd_en) - OUT_BITS'(dec);
    err_d    = err_q || (xfer && !dec);
    addr_d   = sp_rd_en ? addr_q + stride_q : addr_q;
    rem_d    = sp_rd_en ? rem_q - LEN_WIDTH'(1) : rem_q;
    stride_d = stride_q;
    state_d  = state_q;
    case (state_q)
      IDLE: if (start) begin
        addr_d   = base_addr;
        rem_d    = length;
        stride_d = stride;
        state_d  = length == '0 ? FIN : ISSUE;
      end
      ISSUE:   if (sp_rd_en && rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
      DRAIN:   if (out_q == '0 && !out_valid) state_d = FIN;
      default: state_d = IDLE;
    endcase
  end
  // sequencer state registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      rem_q    <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      rem_q    <= rem_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  sp_skid_buffer #(.WIDTH(WIDTH)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_data  (sp_q),
    .in_valid (sp_valid),
    .in_stall (sp_stall),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );
endmodule

// File: tb/tb_scratch_pad_seq_reader.sv
// tb_scratch_pad_seq_reader: scoreboard bench with a delayed-response port model
module tb_scratch_pad_seq_reader;
  logic        clk = 0, rst = 1, start = 0;
  logic [11:0] base_addr = 0, stride = 0;
  logic [12:0] length = 0;
  logic        busy, done, err, sp_rd_en, sp_stall, out_valid;
  logic [11:0] sp_addr;
  logic        sp_full = 0, sp_valid = 0, out_ready = 1;
  logic [63:0] sp_q = 0, out_data;
  typedef struct {logic [11:0] a; int t;} pend_t;
  pend_t       pend[$];
  logic [63:0] exp_q[$];
  logic [11:0] eaddr[$];
  int n_chk = 0, n_pass = 0, cyc = 0, occ = 0, n_req = 0, n_out = 0, n_done = 0;
  int first_rq = -1, last_rq = -1, rel = -1, rdy_pct = 100;
  bit full_rand = 0, go = 0, inj = 0;
  logic [63:0] inj_data = 0;

  always #5 clk = ~clk;

  scratch_pad_seq_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .stride(stride), .busy(busy), .done(done), .err(err), .sp_rd_en(sp_rd_en),
    .sp_addr(sp_addr), .sp_full(sp_full), .sp_q(sp_q), .sp_valid(sp_valid),
    .sp_stall(sp_stall), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_reset();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_rd_en", 64'(sp_rd_en), 64'(0));
    check("rst_addr", 64'(sp_addr), 64'(0));
    check("rst_stall", 64'(sp_stall), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", out_data, 64'(0));
  endtask

  task automatic step();
    bit xin, xout;
    @(negedge clk);
    cyc++;
    start = go;
    go = 0;
    sp_full = full_rand ? 1'($urandom_range(1, 0)) : 1'b0;
    out_ready = $urandom_range(99, 0) < rdy_pct;
    sp_valid = 0;
    sp_q = '0;
    if (inj) begin
      sp_valid = 1;
      sp_q = inj_data;
    end else if (pend.size() != 0 && pend[0].t <= cyc && rel != 0) begin
      sp_valid = 1;
      sp_q = 64'(pend[0].a) + 64'h100;
    end
    #1;
    check("stall_occ", 64'(sp_stall), 64'(occ == 2));
    if (sp_full) check("issue_while_full", 64'(sp_rd_en), 64'(0));
    xin = sp_valid && !sp_stall;
    xout = out_valid && out_ready;
    if (sp_rd_en) begin
      n_req++;
      if (first_rq < 0) first_rq = cyc;
      last_rq = cyc;
      check("req_expected", 64'(eaddr.size() != 0), 64'(1));
      if (eaddr.size() != 0) check("addr", 64'(sp_addr), 64'(eaddr.pop_front()));
      exp_q.push_back(64'(sp_addr) + 64'h100);
      pend.push_back('{sp_addr, cyc + 5});
    end
    if (xout) begin
      n_out++;
      check("out_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
    end
    if (xin) begin
      if (inj) begin
        inj = 0;
        exp_q.push_back(inj_data);
      end else begin
        pend.delete(0);
        if (rel > 0) rel--;
      end
    end
    occ = occ + int'(xin) - int'(xout);
    if (done) n_done++;
  endtask

  task automatic cmd(input logic [11:0] b, input logic [12:0] l, input logic [11:0] s);
    logic [11:0] a;
    a = b;
    for (int i = 0; i < int'(l); i++) begin
      eaddr.push_back(a);
      a = a + s;
    end
    base_addr = b;
    length = l;
    stride = s;
    go = 1;
    n_req = 0;
    n_out = 0;
    n_done = 0;
    first_rq = -1;
    last_rq = -1;
    step();
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (n_done == 0 && k < limit) begin
      step();
      k++;
    end
    check("done_timeout", 64'(n_done), 64'(1));
    step();
    check("busy_after_done", 64'(busy), 64'(0));
    check("done_once", 64'(n_done), 64'(1));
  endtask

  initial begin
    #1 rst = 0;
    #1 chk_reset();
    @(negedge clk);
    rst = 1;

    cmd(12'h010, 13'd4, 12'd1);
    step();
    check("busy_on", 64'(busy), 64'(1));
    wait_done(100);
    check("t1_consecutive", 64'(last_rq - first_rq), 64'(3));
    check("t1_nreq", 64'(n_req), 64'(4));
    check("t1_nout", 64'(n_out), 64'(4));
    check("t1_err", 64'(err), 64'(0));

    cmd(12'hFFE, 13'd3, 12'd3);
    wait_done(100);
    check("t2_nreq", 64'(n_req), 64'(3));
    check("t2_nout", 64'(n_out), 64'(3));
    check("t2_err", 64'(err), 64'(0));

    cmd(12'h123, 13'd0, 12'd5);
    check("t3_busy_idle", 64'(busy), 64'(0));
    step();
    check("t3_busy", 64'(busy), 64'(1));
    check("t3_done", 64'(done), 64'(1));
    step();
    check("t3_busy_off", 64'(busy), 64'(0));
    check("t3_done_off", 64'(done), 64'(0));
    check("t3_nreq", 64'(n_req), 64'(0));

    rel = 0;
    cmd(12'h100, 13'd40, 12'd2);
    repeat (60) step();
    check("t4_budget_nreq", 64'(n_req), 64'(32));
    check("t4_paused", 64'(sp_rd_en), 64'(0));
    rel = 8;
    repeat (30) step();
    check("t4_release_nreq", 64'(n_req), 64'(40));
    check("t4_released", 64'(rel), 64'(0));
    check("t4_pending", 64'(pend.size()), 64'(32));
    rel = -1;
    wait_done(300);
    check("t4_nout", 64'(n_out), 64'(40));

    full_rand = 1;
    rdy_pct = 30;
    cmd(12'($urandom), 13'd100, 12'($urandom));
    wait_done(5000);
    full_rand = 0;
    rdy_pct = 100;
    check("t5_nreq", 64'(n_req), 64'(100));
    check("t5_nout", 64'(n_out), 64'(100));
    check("t5_empty", 64'(exp_q.size()), 64'(0));
    check("t5_err", 64'(err), 64'(0));

    inj_data = 64'hDEAD_BEEF_0000_1234;
    inj = 1;
    step();
    repeat (3) step();
    check("t6_err_set", 64'(err), 64'(1));
    check("t6_inj_fwd", 64'(exp_q.size()), 64'(0));
    cmd(12'h200, 13'd20, 12'd1);
    repeat (4) step();
    check("t6_busy_mid", 64'(busy), 64'(1));
    check("t6_err_sticky", 64'(err), 64'(1));
    @(posedge clk);
    #2 rst = 0;
    #1 chk_reset();
    pend.delete();
    exp_q.delete();
    eaddr.delete();
    occ = 0;
    sp_valid = 0;
    @(negedge clk);
    rst = 1;
    repeat (3) step();
    check("t6_err_cleared", 64'(err), 64'(0));
    check("t6_idle", 64'(busy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
